// File: rtl/bus_arbiter4_if.sv
// Request/grant bundle between four bus masters and the round-robin arbiter.
// The master side drives req/done; the slave side (arbiter) returns grant state.
interface bus_arbiter4_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-master round-robin arbiter with one idle turnaround cycle between owners.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD owned cycles.
module bus_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter4_if.slave bus
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] gnt_q, gnt_nxt;
    logic [1:0] sel_q, sel_nxt;
    logic       busy_q, busy_nxt;
    logic [1:0] owner;
    logic       release_now;

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CW) != 0) begin : g_bad_param
        $error("bus_arbiter4: MAX_HOLD must be 2..255 and below 2**CW");
    end

    // First requester after the last owner; the last owner itself is scanned last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] hold, hold_nxt;
    logic          tout_q, tout_nxt;
    logic          hold_expired;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt_q;
        sel_nxt     = sel_q;
        busy_nxt    = busy_q;
        release_now = 1'b0;
        owner       = rr_pick(bus.req, ptr);
`ifdef ARB_TIMEOUT_EN
        hold_nxt     = hold;
        tout_nxt     = 1'b0;
        hold_expired = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt = OWN;
                    gnt_nxt   = 4'b0001 << owner;
                    sel_nxt   = owner;
                    busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            OWN: begin
                release_now = bus.done[sel_q] || !bus.req[sel_q];
`ifdef ARB_TIMEOUT_EN
                hold_expired = (hold == CW'(MAX_HOLD - 1));
                tout_nxt     = hold_expired && !release_now;
                release_now  = release_now || hold_expired;
`endif
                // sel is left at the old owner so the downstream mux stays quiet.
                if (release_now) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = sel_q;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold != {CW{1'b1}}) begin
                    hold_nxt = hold + CW'(1);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 2'd3;
            gnt_q  <= 4'b0000;
            sel_q  <= 2'd0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt_q  <= gnt_nxt;
            sel_q  <= sel_nxt;
            busy_q <= busy_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold   <= '0;
            tout_q <= 1'b0;
        end else begin
            hold   <= hold_nxt;
            tout_q <= tout_nxt;
        end
    end

    assign bus.timeout = tout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: reset, single grant, rotation, ignored done,
// re-request priority and the optional hold timeout (ARB_TIMEOUT_EN).
module tb_bus_arbiter4;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_arbiter4_if bus();

    bus_arbiter4 #(.MAX_HOLD(MH), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic go_idle();
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%b sel=%0d busy=%b timeout=%b, expected 0000/0/0/0",
                     bus.gnt, bus.sel, bus.busy, bus.timeout);
        end
        rst = 1'b0;
        bus.req = 4'b0100;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_pre_own: got gnt=%b expected 0100", bus.gnt);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got gnt=%b sel=%0d busy=%b, expected 0000/0/0",
                     bus.gnt, bus.sel, bus.busy);
        end
        rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_prio: got gnt=%b sel=%0d expected 0001/0", bus.gnt, bus.sel);
        end
        go_idle();
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b sel=%0d busy=%b expected 0100/2/1",
                     bus.gnt, bus.sel, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_hold: got gnt=%b expected 0100", bus.gnt);
        end
        bus.done = 4'b0100;
        tick();
        bus.done = 4'b0000;
        bus.req  = 4'b0000;
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'd2 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got gnt=%b sel=%0d busy=%b expected 0000/2/0",
                     bus.gnt, bus.sel, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_stay_idle: got gnt=%b busy=%b expected 0000/0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        rst_pulse();
        bus.req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.gnt !== (4'b0001 << order[i]) || bus.sel !== order[i]) begin
                n_fail++;
                $display("FAIL rotation_grant%0d: got gnt=%b sel=%0d expected owner %0d",
                         i, bus.gnt, bus.sel, order[i]);
            end
            tick();
            bus.done = 4'b0001 << order[i];
            tick();
            bus.done = 4'b0000;
            if (i == 4) bus.req = 4'b0000;
            n_checks++;
            if (bus.gnt !== 4'b0000 || bus.sel !== order[i]) begin
                n_fail++;
                $display("FAIL rotation_gap%0d: got gnt=%b sel=%0d expected 0000/%0d",
                         i, bus.gnt, bus.sel, order[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignored_done();
        bus.req = 4'b0010;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL ignored_grant: got gnt=%b expected 0010", bus.gnt);
        end
        bus.req  = 4'b0011;
        bus.done = 4'b1101;
        tick();
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_done_held: got gnt=%b busy=%b expected 0010/1", bus.gnt, bus.busy);
        end
        bus.done = 4'b0000;
        bus.req  = 4'b0001;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'd1) begin
            n_fail++;
            $display("FAIL ignored_drop_release: got gnt=%b sel=%0d expected 0000/1", bus.gnt, bus.sel);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            n_fail++;
            $display("FAIL ignored_next_pending: got gnt=%b sel=%0d expected 0001/0", bus.gnt, bus.sel);
        end
        go_idle();
    endtask

    task automatic test_rerequest();
        bus.req = 4'b1000;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
            n_fail++;
            $display("FAIL rereq_owner3: got gnt=%b sel=%0d expected 1000/3", bus.gnt, bus.sel);
        end
        bus.req  = 4'b1001;
        bus.done = 4'b1000;
        tick();
        bus.done = 4'b0000;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rereq_release: got gnt=%b expected 0000", bus.gnt);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rereq_master0_first: got gnt=%b expected 0001", bus.gnt);
        end
        bus.done = 4'b0001;
        tick();
        bus.done = 4'b0000;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
            n_fail++;
            $display("FAIL rereq_master3_next: got gnt=%b sel=%0d expected 1000/3", bus.gnt, bus.sel);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        rst_pulse();
`ifdef ARB_TIMEOUT_EN
        bus.req = 4'b0011;
        tick();
        for (int i = 0; i < MH; i++) begin
            n_checks++;
            if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_owned%0d: got gnt=%b timeout=%b expected 0001/0",
                         i, bus.gnt, bus.timeout);
            end
            tick();
        end
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_forced: got gnt=%b timeout=%b busy=%b expected 0000/1/0",
                     bus.gnt, bus.timeout, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next_owner: got gnt=%b timeout=%b expected 0010/0",
                     bus.gnt, bus.timeout);
        end
`else
        bus.req = 4'b0001;
        tick();
        for (int i = 0; i < 120; i++) begin
            n_checks++;
            if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL no_timeout_hold%0d: got gnt=%b timeout=%b expected 0001/0",
                         i, bus.gnt, bus.timeout);
            end
            tick();
        end
`endif
        go_idle();
    endtask

    initial begin
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_ignored_done();
        test_rerequest();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Round-robin arbiter sharing one 32-bit SoC resource (data-bus slave port) among four requesters.
- Drives the 2-bit select of the downstream 4:1 word mux (i1..i4 = masters 0..3) plus one-hot grants.
- Holds ownership until the owner signals done or drops its request.
- Inserts one idle turnaround cycle between owners.

Parameters:
- MAX_HOLD, 16, maximum consecutive owned cycles before forced release (used only with ARB_TIMEOUT_EN); legal range 2..255.
- CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per master; bit n = master n.
- done  input  4  one-cycle end-of-transaction pulse per master; only the owner's bit is honoured.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered owner index, wired to the mux op (0→i1, 1→i2, 2→i3, 3→i4).
- busy  output  1  registered; 1 while any grant is active.
- timeout  output  1  registered one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - gnt = 0, sel = 0, busy = 0, timeout = 0.
  - state = IDLE, pointer ptr = 3, so master 0 has first priority.
  - hold counter = 0.
- State machine:
  - Two states, IDLE and OWN.
  - ptr is the last owner index.
- IDLE:
  - Stays IDLE while req = 0.
  - Otherwise, on the edge where a request is sampled, moves to OWN.
  - Owner = first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - On that edge: gnt = one-hot(owner), sel = owner, busy = 1.
  - Latency: grant visible the cycle after req is first sampled high.
- OWN:
  - Ownership holds while req[sel] = 1 and done[sel] = 0.
  - Release occurs when done[sel] = 1 or req[sel] = 0.
  - On release: next state IDLE, gnt = 0, busy = 0, ptr = sel.
  - sel keeps the old owner value during the idle cycle so the mux output does not glitch.
  - Minimum one-cycle gap between owners, even with other requests pending.
- Ignored inputs:
  - done bits of non-owners are ignored in all states.
  - done while IDLE is ignored.
- Simultaneous events:
  - done[sel] together with a new req from the same master: still releases.
  - That master re-competes after the turnaround cycle at lowest priority (ptr = it).
- Fairness: with all four requesting continuously and releasing via done, the grant order is 0,1,2,3,0,…; each master waits at most 3 ownerships.
- Hold counter:
  - Cleared on entry to OWN.
  - Increments each OWN cycle, saturating at 2^CW−1.
- Mid-operation reset: asynchronously returns every register to its reset value immediately.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - If the owner stays in OWN with the hold counter = MAX_HOLD−1 and no release, the next edge forces release (same effects as a normal release).
  - timeout pulses 1 for exactly one cycle, concurrent with the IDLE cycle.
  - The forced master keeps lowest priority for the next arbitration.
- Undefined:
  - No forced release; ownership is unbounded.
  - timeout tied to 0.
  - Counter logic omitted.

Test Plan:
- Reset check: assert rst mid-OWN with gnt = 4'b0100 → gnt = 0, sel = 0, busy = 0 immediately (before the next clk edge); after release, req = 4'b1111 → gnt = 4'b0001.
- Single request: req = 4'b0100 at edge k → gnt = 4'b0100, sel = 2, busy = 1 from k+1; done[2] pulse at edge m → gnt = 0 at m+1, sel stays 2.
- Rotation: req = 4'b1111 held, owner pulses done 2 cycles after each grant → owners 0,1,2,3,0 with one zero-gnt cycle between each.
- Ignored done: owner 1, done = 4'b1101 → grant held; then req[1] dropped → release next edge; next pending req = 4'b0001 is granted after the gap.
- Re-request priority: owner 3 releases while req = 4'b1001 → next grant to master 0, then master 3.
- With ARB_TIMEOUT_EN, MAX_HOLD = 4: owner 0 never sends done → gnt = 0 after 4 owned cycles, timeout = 1 for one cycle, then master 1 granted if requesting; without the macro → grant held 100+ cycles, timeout stays 0.
